// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, data width and default baud divisor.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

    localparam int unsigned DATA_BITS            = 8;
    localparam int unsigned CLKS_PER_BIT_DEFAULT = 427;  // 49.152 MHz / 115200

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } uart_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Single-clock byte FIFO for the UART transmitter.
// Full, empty and count are registered; the pointers carry one extra wrap bit.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             push, pop;

    assign push = wr_en && !full_q;
    assign pop  = rd_en && !empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q + (AW+1)'(push);
        rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
        count_d  = wr_ptr_d - rd_ptr_d;
        full_d   = (count_d == (AW+1)'(DEPTH));
        empty_d  = (wr_ptr_d == rd_ptr_d);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q[AW-1:0]] <= wr_data;
    end

    assign rd_data = mem[rd_ptr_q[AW-1:0]];
    assign full    = full_q;
    assign empty   = empty_q;
    assign count   = count_q;

endmodule

// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter (8E1 when UART_TX_PARITY_EN is defined).
// A valid/ready byte port feeds uart_tx_fifo; a baud-timed FSM serializes onto tx.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [7:0]                    data,
    input  logic                          valid,
    output logic                          ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);

    uart_state_e          state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2:0]           idx_q, idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 tx_q, tx_d;
    logic                 bit_end;
    logic                 fifo_pop, fifo_full, fifo_empty;
    logic [7:0]           fifo_rd_data;
`ifdef UART_TX_PARITY_EN
    logic                 par_q, par_d;
`endif

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .wr_en   (valid),
        .wr_data (data),
        .rd_en   (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign bit_end = (cnt_q == CW'(CLKS_PER_BIT - 1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shreg_d  = shreg_q;
        fifo_pop = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d    = par_q;
`endif
        if (state_q != ST_IDLE) cnt_d = bit_end ? '0 : cnt_q + CW'(1);

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shreg_d  = fifo_rd_data;
`ifdef UART_TX_PARITY_EN
                    par_d    = ^fifo_rd_data;
`endif
                    state_d  = ST_START;
                    cnt_d    = '0;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                    idx_d   = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (idx_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                        idx_d   = '0;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        shreg_d = shreg_q >> 1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                    idx_d   = '0;
                end
            end
`endif
            ST_STOP: begin
                // idx counts stop bits here; the next byte chains straight into START
                if (bit_end) begin
                    if (idx_q == 3'(STOP_BITS - 1)) begin
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            shreg_d  = fifo_rd_data;
`ifdef UART_TX_PARITY_EN
                            par_d    = ^fifo_rd_data;
`endif
                            state_d  = ST_START;
                        end else begin
                            state_d  = ST_IDLE;
                        end
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // line level follows the current state, so tx lags the state by one cycle
        case (state_q)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shreg_q[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = par_q;
`endif
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign tx    = tx_q;
    assign ready = !fifo_full;
    assign busy  = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx; honours UART_TX_PARITY_EN for the frame length.
module tb_uart_tx;

    localparam int CPB = 27;
    localparam int SO  = CPB - 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB  = 11;
`else
    localparam int NB  = 10;
`endif

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [7:0] data = '0;
    logic       valid = 1'b0;
    logic       ready, tx, busy;
    logic [4:0] fifo_count;

    int tests = 0;
    int fails = 0;

    uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (16),
        .STOP_BITS    (1)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .data       (data),
        .valid      (valid),
        .ready      (ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] frame_bits(input logic [7:0] b);
        logic [10:0] f;
        f       = '1;
        f[0]    = 1'b0;
        f[8:1]  = b;
`ifdef UART_TX_PARITY_EN
        f[9]    = ^b;
`endif
        return f;
    endfunction

    task automatic do_reset();
        valid = 1'b0;
        rstn  = 1'b0;
        repeat (3) @(negedge clk);
        rstn  = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_fall(output logic to);
        to = 1'b1;
        for (int i = 0; i < 4 * NB * CPB; i++) begin
            if (tx === 1'b0) begin
                to = 1'b0;
                break;
            end
            @(negedge clk);
        end
    endtask

    // k0 = negedges already elapsed since the start bit began (0: wait for it)
    task automatic recv_frame(input int k0, output logic [7:0] b, output logic ok);
        logic [10:0] s;
        logic        to;
        s  = '1;
        to = 1'b0;
        if (k0 == 0) wait_fall(to);
        if (to) begin
            b  = '0;
            ok = 1'b0;
        end else begin
            repeat (SO - k0) @(negedge clk);
            for (int i = 0; i < NB; i++) begin
                s[i] = tx;
                if (i < NB - 1) repeat (CPB) @(negedge clk);
            end
            b  = s[8:1];
            ok = (s[0] === 1'b0) && (s[NB-1] === 1'b1);
`ifdef UART_TX_PARITY_EN
            ok = ok && (s[9] === ^s[8:1]);
`endif
        end
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (tx !== 1'b1) begin fails++; $display("FAIL reset_tx got %b want 1", tx); end
        tests++; if (ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", ready); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        tests++; if (fifo_count !== 5'd0) begin fails++; $display("FAIL reset_count got %0d want 0", fifo_count); end
    endtask

    task automatic test_single();
        logic [10:0] f;
        int          tx_err, busy_err;
        f = frame_bits(8'h41);
        data = 8'h41; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        tests++; if (fifo_count !== 5'd1) begin fails++; $display("FAIL single_count_push got %0d want 1", fifo_count); end
        @(negedge clk);
        tests++; if ({tx, busy, fifo_count} !== {1'b1, 1'b1, 5'd0}) begin
            fails++; $display("FAIL single_pop tx/busy/count got %b/%b/%0d want 1/1/0", tx, busy, fifo_count);
        end
        @(negedge clk);
        tx_err = 0; busy_err = 0;
        for (int k = 0; k < NB * CPB + 3; k++) begin
            if (tx !== ((k < NB * CPB) ? f[k / CPB] : 1'b1)) tx_err++;
            if (busy !== (k < NB * CPB - 1)) busy_err++;
            @(negedge clk);
        end
        tests++; if (tx_err != 0) begin fails++; $display("FAIL single_wave got %0d bad cycles want 0", tx_err); end
        tests++; if (busy_err != 0) begin fails++; $display("FAIL single_busy got %0d bad cycles want 0", busy_err); end
    endtask

    task automatic test_back_to_back();
        logic [10:0] f1, f2;
        int          tx_err, busy_err;
        f1 = frame_bits(8'h55);
        f2 = frame_bits(8'hAA);
        data = 8'h55; valid = 1'b1;
        @(negedge clk);
        data = 8'hAA;
        @(negedge clk);
        valid = 1'b0;
        tests++; if (fifo_count !== 5'd1) begin fails++; $display("FAIL b2b_pushpop_count got %0d want 1", fifo_count); end
        @(negedge clk);
        tx_err = 0; busy_err = 0;
        for (int k = 0; k < 2 * NB * CPB + 3; k++) begin
            if (tx !== ((k < NB * CPB) ? f1[k / CPB] :
                        (k < 2 * NB * CPB) ? f2[(k - NB * CPB) / CPB] : 1'b1)) tx_err++;
            if (busy !== (k < 2 * NB * CPB - 1)) busy_err++;
            @(negedge clk);
        end
        tests++; if (tx_err != 0) begin fails++; $display("FAIL b2b_wave got %0d bad cycles want 0", tx_err); end
        tests++; if (busy_err != 0) begin fails++; $display("FAIL b2b_busy got %0d bad cycles want 0", busy_err); end
    endtask

    task automatic test_fill();
        logic [7:0] b;
        logic       ok;
        int         bad, zeros;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            data = 8'h10 + 8'(i); valid = 1'b1;
            @(negedge clk);
            if (i == 1) begin
                tests++; if (fifo_count !== 5'd1) begin fails++; $display("FAIL fill_pushpop got %0d want 1", fifo_count); end
            end
            if (i == 15) begin
                tests++; if ({ready, fifo_count} !== {1'b1, 5'd15}) begin
                    fails++; $display("FAIL fill_15 ready/count got %b/%0d want 1/15", ready, fifo_count);
                end
            end
            if (i == 16) begin
                tests++; if ({ready, fifo_count} !== {1'b0, 5'd16}) begin
                    fails++; $display("FAIL fill_full ready/count got %b/%0d want 0/16", ready, fifo_count);
                end
            end
        end
        valid = 1'b0;
        tests++; if (fifo_count !== 5'd16) begin fails++; $display("FAIL fill_drop got %0d want 16", fifo_count); end
        bad = 0;
        for (int j = 0; j < 17; j++) begin
            recv_frame((j == 0) ? 17 : 0, b, ok);
            if (!ok || b !== 8'h10 + 8'(j)) begin
                bad++;
                $display("FAIL fill_frame%0d got %h ok=%b want %h", j, b, ok, 8'h10 + 8'(j));
            end
        end
        tests++; if (bad != 0) fails++;
        zeros = 0;
        for (int k = 0; k < 2 * NB * CPB; k++) begin
            if (tx !== 1'b1) zeros++;
            @(negedge clk);
        end
        tests++; if ({zeros, busy, fifo_count} !== {32'd0, 1'b0, 5'd0}) begin
            fails++; $display("FAIL fill_after got extra=%0d busy=%b count=%0d want 0/0/0", zeros, busy, fifo_count);
        end
    endtask

    task automatic test_full_swap();
        logic [7:0] b, e;
        logic       ok;
        int         bad;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            data = 8'h80 + 8'(i); valid = 1'b1;
            @(negedge clk);
        end
        valid = 1'b0;
        tests++; if (fifo_count !== 5'd15) begin fails++; $display("FAIL swap_pre got %0d want 15", fifo_count); end
        repeat (NB * CPB - 15) @(negedge clk);
        tests++; if (fifo_count !== 5'd15) begin fails++; $display("FAIL swap_hold got %0d want 15", fifo_count); end
        data = 8'hC0; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        tests++; if (fifo_count !== 5'd15) begin fails++; $display("FAIL swap_same_edge got %0d want 15", fifo_count); end
        bad = 0;
        for (int j = 1; j <= 16; j++) begin
            e = (j == 16) ? 8'hC0 : 8'h80 + 8'(j);
            recv_frame(0, b, ok);
            if (!ok || b !== e) begin
                bad++;
                $display("FAIL swap_frame%0d got %h ok=%b want %h", j, b, ok, e);
            end
        end
        tests++; if (bad != 0) fails++;
    endtask

    task automatic test_abort();
        int errs;
        do_reset();
        data = 8'h00; valid = 1'b1;
        @(negedge clk);
        data = 8'h5A;
        @(negedge clk);
        data = 8'h3C;
        @(negedge clk);
        valid = 1'b0;
        tests++; if (tx !== 1'b0) begin fails++; $display("FAIL abort_start got %b want 0", tx); end
        repeat (5 * CPB + 13) @(negedge clk);
        tests++; if ({tx, fifo_count} !== {1'b0, 5'd2}) begin
            fails++; $display("FAIL abort_bit4 tx/count got %b/%0d want 0/2", tx, fifo_count);
        end
        rstn = 1'b0;
        #1;
        tests++; if ({tx, busy, ready, fifo_count} !== {1'b1, 1'b0, 1'b1, 5'd0}) begin
            fails++; $display("FAIL abort_async tx/busy/ready/count got %b/%b/%b/%0d want 1/0/1/0", tx, busy, ready, fifo_count);
        end
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        errs = 0;
        for (int k = 0; k < 3 * NB * CPB; k++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) errs++;
        end
        tests++; if ({errs, fifo_count} !== {32'd0, 5'd0}) begin
            fails++; $display("FAIL abort_quiet got bad=%0d count=%0d want 0/0", errs, fifo_count);
        end
    endtask

    task automatic test_parity();
        logic [10:0] f;
        int          tx_err, busy_err;
        do_reset();
        f = frame_bits(8'h07);
        data = 8'h07; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tx_err = 0; busy_err = 0;
        for (int k = 0; k < 11 * CPB + 3; k++) begin
            if (tx !== ((k < NB * CPB) ? f[k / CPB] : 1'b1)) tx_err++;
            if (busy !== (k < NB * CPB - 1)) busy_err++;
            @(negedge clk);
        end
        tests++; if (tx_err != 0) begin fails++; $display("FAIL parity_wave got %0d bad cycles want 0", tx_err); end
        tests++; if (busy_err != 0) begin fails++; $display("FAIL parity_len got %0d bad cycles want 0 (%0d-bit frame)", busy_err, NB); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_fill();
        test_full_swap();
        test_abort();
        test_parity();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
